// File: rtl/mem_dma_arbiter_pkg.sv
// Shared types and constants for the bus-mastering DMA arbiter.
package mem_dma_arbiter_pkg;

  localparam int ADDR_W_DEF      = 17;
  localparam int LEN_W_DEF       = 16;
  localparam int ACK_TIMEOUT_DEF = 65535;

  // 128k RAM is eight 16k banks: {bank[2:0], A[13:0]}
  localparam int BANK_W = 3;
  localparam int PAGE_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_XFER    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  function automatic logic [BANK_W+PAGE_W-1:0] bank_addr(input logic [BANK_W-1:0] bank,
                                                         input logic [PAGE_W-1:0] a);
    return {bank, a};
  endfunction

endpackage

// File: rtl/mem_dma_arbiter_busack_sync.sv
// Two-flop synchronizer for the Z80 nBUSACK line; idles high (bus not granted).
module busack_sync (
  input  logic clock_25,
  input  logic RESET_N,
  input  logic async_in,
  output logic sync_out
);

  logic meta_r;
  logic sync_r;

  // metastability filter, reset to the released level
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
    end
  end

  assign sync_out = sync_r;

endmodule

// File: rtl/mem_dma_arbiter.sv
// DMA arbiter: takes the Z80 bus via nBUSRQ/nBUSACK and writes a byte stream into RAM.
module mem_dma_arbiter
  import mem_dma_arbiter_pkg::*;
#(
  parameter int          ADDR_W      = ADDR_W_DEF,
  parameter int          LEN_W       = LEN_W_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clock_25,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  output logic              src_ready,
  input  logic              nBUSACK,
  output logic              nBUSRQ,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int                WAIT_W    = $clog2(ACK_TIMEOUT + 32'd1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 32'd1);

  state_t              state_r;
  logic [ADDR_W-1:0]   base_r;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    count_r;
  logic [WAIT_W-1:0]   wait_r;
  logic                to_flag_r;
  logic                nbusrq_r;
  logic                mem_sel_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [7:0]          mem_data_r;
  logic                mem_wren_r;
  logic                src_ready_r;
  logic                busy_r;
  logic                done_r;
  logic                timeout_r;
  logic                ack_sync_s;

  busack_sync u_busack_sync (
    .clock_25 (clock_25),
    .RESET_N  (RESET_N),
    .async_in (nBUSACK),
    .sync_out (ack_sync_s)
  );

  // transfer FSM with all outputs registered; mem_sel and nBUSRQ always change on the same edge when releasing
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      state_r     <= ST_IDLE;
      base_r      <= '0;
      len_r       <= '0;
      count_r     <= '0;
      wait_r      <= '0;
      to_flag_r   <= 1'b0;
      nbusrq_r    <= 1'b1;
      mem_sel_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_data_r  <= 8'h00;
      mem_wren_r  <= 1'b0;
      src_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
      mem_wren_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && (length != '0)) begin
            base_r    <= base_addr;
            len_r     <= length;
            count_r   <= '0;
            wait_r    <= '0;
            to_flag_r <= 1'b0;
            nbusrq_r  <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= ST_REQ;
          end else if (start) begin
            done_r <= 1'b1;
          end
        end
        ST_REQ: begin
          if (abort) begin
            nbusrq_r <= 1'b1;
            state_r  <= ST_RELEASE;
          end else if (!ack_sync_s) begin
            mem_sel_r   <= 1'b1;
            src_ready_r <= 1'b1;
            state_r     <= ST_XFER;
          end else if (wait_r == WAIT_LAST) begin
            nbusrq_r  <= 1'b1;
            to_flag_r <= 1'b1;
            state_r   <= ST_RELEASE;
          end else begin
            wait_r <= wait_r + WAIT_W'(1);
          end
        end
        ST_XFER: begin
          if (abort) begin
            nbusrq_r    <= 1'b1;
            mem_sel_r   <= 1'b0;
            src_ready_r <= 1'b0;
            state_r     <= ST_RELEASE;
          end else if (src_valid && src_ready_r) begin
            mem_addr_r  <= base_r + ADDR_W'(count_r);
            mem_data_r  <= src_data;
            mem_wren_r  <= 1'b1;
            src_ready_r <= 1'b0;
            count_r     <= count_r + LEN_W'(1);
            state_r     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (abort || (count_r == len_r)) begin
            nbusrq_r  <= 1'b1;
            mem_sel_r <= 1'b0;
            state_r   <= ST_RELEASE;
          end else begin
            src_ready_r <= 1'b1;
            state_r     <= ST_XFER;
          end
        end
        ST_RELEASE: begin
          if (ack_sync_s) begin
            busy_r    <= 1'b0;
            done_r    <= ~to_flag_r;
            timeout_r <= to_flag_r;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          nbusrq_r    <= 1'b1;
          mem_sel_r   <= 1'b0;
          src_ready_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign src_ready = src_ready_r;
  assign nBUSRQ    = nbusrq_r;
  assign mem_sel   = mem_sel_r;
  assign mem_addr  = mem_addr_r;
  assign mem_data  = mem_data_r;
  assign mem_wren  = mem_wren_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign timeout   = timeout_r;

endmodule

// File: doc/mem_dma_arbiter.md
# mem_dma_arbiter

Bus-mastering DMA arbiter that lets a byte-stream source write into the 128k RAM while the Z80 is held off the bus. It sits between a block-load source (snapshot/TAP bulk loader) and memory port A. It acquires the bus via the Z80 nBUSRQ/nBUSACK handshake and sequences one write per accepted byte. It then releases the bus and reports completion.

## Interface
- ADDR_W, 17, RAM address width (128k)
- LEN_W, 16, transfer length counter width
- ACK_TIMEOUT, 65535, clock_25 cycles to wait for nBUSACK before giving up
- clock_25  in  1  system clock
- RESET_N  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  terminate transfer, release bus
- base_addr  in  ADDR_W  first RAM address; sampled with start
- length  in  LEN_W  byte count; sampled with start
- src_valid  in  1  source byte available
- src_data  in  8  source byte
- src_ready  out  1  arbiter accepts byte this cycle
- nBUSACK  in  1  from Z80, asynchronous to clock_25
- nBUSRQ  out  1  to Z80, active-low
- mem_sel  out  1  1 = arbiter drives memory port A mux (CPU address/data/wren ignored)
- mem_addr  out  ADDR_W  RAM write address
- mem_data  out  8  RAM write data
- mem_wren  out  1  RAM write strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, transfer finished normally
- timeout  out  1  one-cycle pulse, bus grant never arrived

## Operation
- States: IDLE, REQ, XFER, WRITE, RELEASE.
- IDLE: start=1 with length≠0 -> latch base_addr/length, clear count, go REQ. start with length=0 -> done pulse next cycle, stay IDLE, nBUSRQ untouched.
- REQ: nBUSRQ=0; 2-flop synchronizer on nBUSACK; synced low -> go XFER, mem_sel=1. Wait counter reaching ACK_TIMEOUT -> go RELEASE, flag timeout.
- XFER: src_ready=1; src_valid&src_ready -> register mem_addr=base+count (mod 2^ADDR_W, wraps 1FFFF->00000), mem_data=src_data, go WRITE.
- WRITE: mem_wren=1 for exactly one cycle, src_ready=0, count+1; count==length -> RELEASE, else XFER.
- RELEASE: mem_sel=0, nBUSRQ=1; wait synced nBUSACK high -> IDLE plus done pulse (or timeout pulse if entered via timeout).
- abort in REQ or XFER -> RELEASE next cycle; abort in WRITE -> current write completes, then RELEASE; abort in IDLE/RELEASE ignored. Aborted transfers end with done pulse.
- start while busy ignored.
- Reset: nBUSRQ=1; mem_sel, mem_wren, src_ready, busy, done, timeout=0; mem_addr=0, mem_data=0; state IDLE. Reset mid-transfer releases bus immediately.

## Timing
- start at cycle 0 -> nBUSRQ low at cycle 1.
- nBUSACK falling edge -> mem_sel high 3 clock_25 cycles later (2 sync + state register).
- Max throughput 1 byte per 2 cycles (XFER accept, WRITE strobe); mem_wren always one cycle after acceptance.
- mem_addr/mem_data stable for the whole WRITE cycle and held thereafter until next accept.
- mem_sel never high while nBUSRQ high except the cycle entering RELEASE (mem_sel falls same edge nBUSRQ rises).
- done/timeout asserted the cycle state returns to IDLE; busy low that same cycle.

## Structure
- Shared package: state encoding enum, ADDR_W/LEN_W defaults, memory-map constant for bank addressing ({bank[2:0], A[13:0]}).
- One sub-module: busack_sync (2-flop synchronizer, reset value 1).
- Counters and FSM in the top; no other hierarchy.

## Test plan
- start, base=0x14000, length=3, nBUSACK drops 10 cycles after nBUSRQ, bytes AA,55,C3 always valid -> writes to 0x14000/14001/14002 in order, one mem_wren each, done pulse once nBUSACK returns high.
- base=0x1FFFE, length=4 -> writes at 1FFFE, 1FFFF, 00000, 00001.
- length=0 -> done pulse next cycle, nBUSRQ never low, no mem_wren.
- nBUSACK held high, ACK_TIMEOUT=100 -> nBUSRQ low 100 cycles, then high, timeout pulse, no write, mem_sel never 1.
- abort asserted during WRITE of byte 2 of 10 -> byte 2 written, no byte 3, nBUSRQ high next cycle, done pulse after nBUSACK high.
- RESET_N low mid-XFER -> next cycle nBUSRQ=1, mem_sel=0, busy=0; start ignored while busy, src_valid gaps stall without spurious writes.
